// File: rtl/cp0_regfile_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, write masks and constant IDs.
// Also used by the exception encoder, so keep encodings stable.
package cp0_defs;

  localparam logic [4:0] CP0_REG_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_REG_COUNT    = 5'd9;
  localparam logic [4:0] CP0_REG_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_REG_STATUS   = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_REG_EPC      = 5'd14;
  localparam logic [4:0] CP0_REG_PRID     = 5'd15;
  localparam logic [4:0] CP0_REG_CONFIG   = 5'd16;

  localparam logic [31:0] EXC_INT  = 32'h0000_0001;
  localparam logic [31:0] EXC_ADEL = 32'h0000_0004;
  localparam logic [31:0] EXC_ADES = 32'h0000_0005;
  localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
  localparam logic [31:0] EXC_BP   = 32'h0000_0009;
  localparam logic [31:0] EXC_RI   = 32'h0000_000a;
  localparam logic [31:0] EXC_OV   = 32'h0000_000c;
  localparam logic [31:0] EXC_ERET = 32'h0000_000e;

  localparam logic [31:0] STATUS_WMASK = 32'h0000_ff03;
  localparam logic [31:0] STATUS_RESET = 32'h0040_0000;
  localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;
  localparam logic [31:0] PRID_VALUE   = 32'h0000_4220;
  localparam logic [31:0] CONFIG_VALUE = 32'h0000_8000;

  localparam int STATUS_EXL_BIT = 1;
  localparam int CAUSE_BD_BIT   = 31;

  function automatic logic is_commit_exc(input logic [31:0] et);
    return (et == EXC_INT) || (et == EXC_ADEL) || (et == EXC_ADES) || (et == EXC_SYS) ||
           (et == EXC_BP)  || (et == EXC_RI)   || (et == EXC_OV);
  endfunction

  // Interrupts are reported as ExcCode 0; every other code is its own ExcCode.
  function automatic logic [4:0] exc_code(input logic [31:0] et);
    return (et == EXC_INT) ? 5'd0 : et[4:0];
  endfunction

endpackage

// File: rtl/cp0_regfile_if.sv
// Bus between the pipeline/exception encoder and the CP0 register file.
interface cp0_regfile_if;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [4:0]  raddr_i;
  logic [31:0] data_i;
  logic [5:0]  int_i;
  logic [31:0] excepttype_i;
  logic [31:0] current_inst_addr_i;
  logic        is_in_delayslot_i;
  logic [31:0] bad_addr_i;
  logic [31:0] data_o;
  logic [31:0] status_o;
  logic [31:0] cause_o;
  logic [31:0] epc_o;
  logic [31:0] badvaddr_o;
  logic [31:0] count_o;
  logic [31:0] compare_o;
  logic        timer_int_o;

  modport slave (
    input  we_i, waddr_i, raddr_i, data_i, int_i, excepttype_i,
           current_inst_addr_i, is_in_delayslot_i, bad_addr_i,
    output data_o, status_o, cause_o, epc_o, badvaddr_o, count_o, compare_o, timer_int_o
  );

  modport master (
    output we_i, waddr_i, raddr_i, data_i, int_i, excepttype_i,
           current_inst_addr_i, is_in_delayslot_i, bad_addr_i,
    input  data_o, status_o, cause_o, epc_o, badvaddr_o, count_o, compare_o, timer_int_o
  );
endinterface

// File: rtl/cp0_regfile_timer.sv
// Count/Compare timer: Count advances every second cycle; match raises a sticky interrupt
// that only a Compare write clears.
module cp0_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we_i,
  input  logic        compare_we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        timer_int_o
);

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        tick_q, tick_d;
  logic        timer_int_q, timer_int_d;

  always_comb begin
    tick_d      = ~tick_q;
    count_d     = tick_q ? count_q + 32'd1 : count_q;
    compare_d   = compare_q;
    timer_int_d = timer_int_q;
    if (count_we_i) begin
      count_d = wdata_i;
    end
    if (compare_we_i) begin
      compare_d   = wdata_i;
      timer_int_d = 1'b0;
    end else if ((compare_q != 32'd0) && (count_q == compare_q)) begin
      timer_int_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= 32'd0;
      compare_q   <= 32'd0;
      tick_q      <= 1'b0;
      timer_int_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      compare_q   <= compare_d;
      tick_q      <= tick_d;
      timer_int_q <= timer_int_d;
    end
  end

  assign count_o     = count_q;
  assign compare_o   = compare_q;
  assign timer_int_o = timer_int_q;

endmodule

// File: rtl/cp0_regfile.sv
// CP0 register file: mtc0/mfc0 access plus exception commit of EPC, Cause, Status.EXL, BadVAddr.
// All updates land one cycle after the inputs; reads are combinational with no write bypass.
module cp0_regfile
  import cp0_defs::*;
(
  input  logic          clk,
  input  logic          rst,
  cp0_regfile_if.slave  cp0
);

  logic [31:0] status_q, status_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badvaddr_q, badvaddr_d;
  logic [31:0] count;
  logic [31:0] compare;
  logic        timer_int;
  logic        commit;
  logic        eret;

  assign commit = is_commit_exc(cp0.excepttype_i);
  assign eret   = (cp0.excepttype_i == EXC_ERET);

  cp0_timer u_timer (
    .clk          (clk),
    .rst          (rst),
    .count_we_i   (cp0.we_i && (cp0.waddr_i == CP0_REG_COUNT)),
    .compare_we_i (cp0.we_i && (cp0.waddr_i == CP0_REG_COMPARE)),
    .wdata_i      (cp0.data_i),
    .count_o      (count),
    .compare_o    (compare),
    .timer_int_o  (timer_int)
  );

  always_comb begin
    status_d   = status_q;
    cause_d    = cause_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;

    cause_d[15:10] = {cp0.int_i[5] | timer_int, cp0.int_i[4:0]};

    if (cp0.we_i) begin
      case (cp0.waddr_i)
        CP0_REG_STATUS: status_d = (status_q & ~STATUS_WMASK) | (cp0.data_i & STATUS_WMASK);
        CP0_REG_CAUSE:  cause_d  = (cause_d & ~CAUSE_WMASK) | (cp0.data_i & CAUSE_WMASK);
        CP0_REG_EPC:    epc_d    = cp0.data_i;
        default: ;
      endcase
    end

    // Exception fields take priority over a same-cycle mtc0; with EXL already set
    // the original EPC/BD of the outer exception must survive.
    if (commit) begin
      if (!status_q[STATUS_EXL_BIT]) begin
        epc_d                 = cp0.is_in_delayslot_i ? cp0.current_inst_addr_i - 32'd4
                                                      : cp0.current_inst_addr_i;
        cause_d[CAUSE_BD_BIT] = cp0.is_in_delayslot_i;
      end else begin
        epc_d = epc_q;
      end
      status_d[STATUS_EXL_BIT] = 1'b1;
      cause_d[6:2]             = exc_code(cp0.excepttype_i);
      if ((cp0.excepttype_i == EXC_ADEL) || (cp0.excepttype_i == EXC_ADES)) begin
        badvaddr_d = cp0.bad_addr_i;
      end
    end else if (eret) begin
      status_d[STATUS_EXL_BIT] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status_q   <= STATUS_RESET;
      cause_q    <= 32'd0;
      epc_q      <= 32'd0;
      badvaddr_q <= 32'd0;
    end else begin
      status_q   <= status_d;
      cause_q    <= cause_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
    end
  end

  always_comb begin
    case (cp0.raddr_i)
      CP0_REG_BADVADDR: cp0.data_o = badvaddr_q;
      CP0_REG_COUNT:    cp0.data_o = count;
      CP0_REG_COMPARE:  cp0.data_o = compare;
      CP0_REG_STATUS:   cp0.data_o = status_q;
      CP0_REG_CAUSE:    cp0.data_o = cause_q;
      CP0_REG_EPC:      cp0.data_o = epc_q;
      CP0_REG_PRID:     cp0.data_o = PRID_VALUE;
      CP0_REG_CONFIG:   cp0.data_o = CONFIG_VALUE;
      default:          cp0.data_o = 32'd0;
    endcase
  end

  assign cp0.status_o    = status_q;
  assign cp0.cause_o     = cause_q;
  assign cp0.epc_o       = epc_q;
  assign cp0.badvaddr_o  = badvaddr_q;
  assign cp0.count_o     = count;
  assign cp0.compare_o   = compare;
  assign cp0.timer_int_o = timer_int;

endmodule

// File: tb/tb_cp0_regfile.sv
// Scoreboard bench for cp0_regfile: directed scenarios followed by random traffic, all
// checked against a field-level reference model of the CP0 registers.
module tb_cp0_regfile;

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  wa;
    logic [4:0]  ra;
    logic [31:0] d;
    logic [5:0]  irq;
    logic [31:0] et;
    logic [31:0] pc;
    logic        ds;
    logic [31:0] ba;
  } stim_t;

  typedef struct {
    logic [31:0] data;
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] epc;
    logic [31:0] badv;
    logic [31:0] count;
    logic [31:0] compare;
    logic        tint;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];

  cp0_regfile_if cp0_if();

  cp0_regfile dut (
    .clk (clk),
    .rst (rst),
    .cp0 (cp0_if)
  );

  always #5 clk = ~clk;

  // Reference model state, kept as individual architectural fields.
  logic        m_valid = 1'b0;
  logic [31:0] m_status, m_epc, m_badv, m_count, m_compare;
  logic [1:0]  m_sw;
  logic        m_bd, m_tick, m_tint;
  logic [4:0]  m_code;
  logic [5:0]  m_ip;

  function automatic logic [31:0] m_cause();
    return {m_bd, 15'd0, m_ip, m_sw, 1'b0, m_code, 2'b00};
  endfunction

  function automatic logic m_is_exc(input logic [31:0] et);
    return et inside {32'h1, 32'h4, 32'h5, 32'h8, 32'h9, 32'ha, 32'hc};
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] ra);
    case (ra)
      5'd8:    return m_badv;
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return m_status;
      5'd13:   return m_cause();
      5'd14:   return m_epc;
      5'd15:   return 32'h0000_4220;
      5'd16:   return 32'h0000_8000;
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_step(input stim_t s);
    logic [31:0] n_status, n_epc, n_badv, n_count, n_compare;
    logic [1:0]  n_sw;
    logic        n_bd, n_tint;
    logic [4:0]  n_code;
    if (s.rst) begin
      m_status = 32'h0040_0000; m_epc = 0; m_badv = 0; m_count = 0; m_compare = 0;
      m_sw = 0; m_bd = 0; m_code = 0; m_ip = 0; m_tick = 0; m_tint = 0;
      m_valid = 1'b1;
      return;
    end
    n_status = m_status; n_epc = m_epc; n_badv = m_badv; n_compare = m_compare;
    n_sw = m_sw; n_bd = m_bd; n_code = m_code;
    n_count = m_count + (m_tick ? 32'd1 : 32'd0);
    n_tint = m_tint;
    if (m_compare != 0 && m_count == m_compare) n_tint = 1'b1;
    if (s.we) begin
      case (s.wa)
        5'd9:  n_count = s.d;
        5'd11: begin n_compare = s.d; n_tint = 1'b0; end
        5'd12: n_status = 32'h0040_0000 | (s.d & 32'h0000_ff03);
        5'd13: n_sw = s.d[9:8];
        5'd14: n_epc = s.d;
        default: ;
      endcase
    end
    if (m_is_exc(s.et)) begin
      if (m_status[1] == 1'b0) begin
        n_epc = s.ds ? s.pc - 32'd4 : s.pc;
        n_bd  = s.ds;
      end
      n_status[1] = 1'b1;
      n_code = (s.et == 32'h1) ? 5'd0 : s.et[4:0];
      if (s.et == 32'h4 || s.et == 32'h5) n_badv = s.ba;
    end else if (s.et == 32'he) begin
      n_status[1] = 1'b0;
    end
    m_ip = {s.irq[5] | m_tint, s.irq[4:0]};
    m_status = n_status; m_epc = n_epc; m_badv = n_badv; m_count = n_count;
    m_compare = n_compare; m_sw = n_sw; m_bd = n_bd; m_code = n_code; m_tint = n_tint;
    m_tick = ~m_tick;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s.rst = 0; s.we = 0; s.wa = 0; s.ra = 5'd15; s.d = 0; s.irq = 0;
    s.et = 0; s.pc = 0; s.ds = 0; s.ba = 0;
    return s;
  endfunction

  // Applies one cycle of stimulus just after a rising edge and returns just after the next.
  task automatic drive(input stim_t s);
    exp_t e;
    rst = s.rst;
    cp0_if.we_i = s.we; cp0_if.waddr_i = s.wa; cp0_if.raddr_i = s.ra; cp0_if.data_i = s.d;
    cp0_if.int_i = s.irq; cp0_if.excepttype_i = s.et; cp0_if.current_inst_addr_i = s.pc;
    cp0_if.is_in_delayslot_i = s.ds; cp0_if.bad_addr_i = s.ba;
    if (m_valid) begin
      e.data = m_read(s.ra); e.status = m_status; e.cause = m_cause(); e.epc = m_epc;
      e.badv = m_badv; e.count = m_count; e.compare = m_compare; e.tint = m_tint;
      exp_q.push_back(e);
    end
    m_step(s);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("data_o",      cp0_if.data_o,      e.data);
      chk("status_o",    cp0_if.status_o,    e.status);
      chk("cause_o",     cp0_if.cause_o,     e.cause);
      chk("epc_o",       cp0_if.epc_o,       e.epc);
      chk("badvaddr_o",  cp0_if.badvaddr_o,  e.badv);
      chk("count_o",     cp0_if.count_o,     e.count);
      chk("compare_o",   cp0_if.compare_o,   e.compare);
      chk("timer_int_o", {31'd0, cp0_if.timer_int_o}, {31'd0, e.tint});
    end
  end

  initial begin
    stim_t s;
    int    waited;
    logic [31:0] et_tab [14] = '{32'h0, 32'h0, 32'h0, 32'h1, 32'h4, 32'h5, 32'h8,
                                 32'h9, 32'ha, 32'hc, 32'he, 32'h2, 32'hd, 32'h20};
    logic [4:0]  wa_tab [9]  = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd0};

    s = idle();
    cp0_if.we_i = 0; cp0_if.waddr_i = 0; cp0_if.raddr_i = 0; cp0_if.data_i = 0;
    cp0_if.int_i = 0; cp0_if.excepttype_i = 0; cp0_if.current_inst_addr_i = 0;
    cp0_if.is_in_delayslot_i = 0; cp0_if.bad_addr_i = 0;
    @(posedge clk);
    #1;

    // Reset
    s = idle(); s.rst = 1; drive(s);
    chk("rst_status", cp0_if.status_o, 32'h0040_0000);
    chk("rst_prid",   cp0_if.data_o,   32'h0000_4220);
    chk("rst_cause",  cp0_if.cause_o,  32'h0);
    chk("rst_count",  cp0_if.count_o,  32'h0);

    // Syscall then ERET
    s = idle(); s.et = 32'h8; s.pc = 32'hbfc0_0100; drive(s);
    chk("sys_epc",  cp0_if.epc_o, 32'hbfc0_0100);
    chk("sys_code", {27'd0, cp0_if.cause_o[6:2]}, 32'h8);
    chk("sys_bd",   {31'd0, cp0_if.cause_o[31]}, 32'h0);
    chk("sys_exl",  {31'd0, cp0_if.status_o[1]}, 32'h1);
    s = idle(); s.et = 32'he; drive(s);
    chk("eret_exl", {31'd0, cp0_if.status_o[1]}, 32'h0);

    // Delay-slot ADEL followed by a nested overflow
    s = idle(); s.et = 32'h4; s.pc = 32'h8000_0010; s.ds = 1; s.ba = 32'h8000_0003; drive(s);
    chk("adel_epc",  cp0_if.epc_o, 32'h8000_000c);
    chk("adel_bd",   {31'd0, cp0_if.cause_o[31]}, 32'h1);
    chk("adel_badv", cp0_if.badvaddr_o, 32'h8000_0003);
    s = idle(); s.et = 32'hc; s.pc = 32'h8000_0020; drive(s);
    chk("nest_epc",  cp0_if.epc_o, 32'h8000_000c);
    chk("nest_code", {27'd0, cp0_if.cause_o[6:2]}, 32'hc);
    s = idle(); s.et = 32'he; drive(s);

    // mtc0 masking
    s = idle(); s.we = 1; s.wa = 5'd12; s.d = 32'hffff_ffff; drive(s);
    chk("status_mask", cp0_if.status_o, 32'h0040_ff03);
    s = idle(); s.we = 1; s.wa = 5'd12; s.d = 32'h0; drive(s);
    s = idle(); s.we = 1; s.wa = 5'd13; s.d = 32'hffff_ffff; drive(s);
    chk("cause_sw",   {30'd0, cp0_if.cause_o[9:8]}, 32'h3);
    chk("cause_hi",   {17'd0, cp0_if.cause_o[30:16]}, 32'h0);
    chk("cause_ip",   {26'd0, cp0_if.cause_o[15:10]}, 32'h0);

    // mtc0 EPC colliding with an exception
    s = idle(); s.we = 1; s.wa = 5'd14; s.d = 32'h1234_5678; s.et = 32'hc; s.pc = 32'h8000_0040;
    drive(s);
    chk("collide_epc", cp0_if.epc_o, 32'h8000_0040);
    s = idle(); s.et = 32'he; drive(s);

    // Timer
    s = idle(); s.we = 1; s.wa = 5'd11; s.d = 32'd5; drive(s);
    s = idle(); s.we = 1; s.wa = 5'd9;  s.d = 32'd0; drive(s);
    waited = 0;
    while (cp0_if.timer_int_o !== 1'b1 && waited < 30) begin
      drive(idle());
      waited++;
    end
    chk("timer_fired", {31'd0, cp0_if.timer_int_o}, 32'h1);
    drive(idle());
    chk("timer_ip7", {31'd0, cp0_if.cause_o[15]}, 32'h1);
    s = idle(); s.we = 1; s.wa = 5'd11; s.d = 32'd0; drive(s);
    chk("timer_clear", {31'd0, cp0_if.timer_int_o}, 32'h0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      s = idle();
      s.rst = ($urandom_range(0, 79) == 0);
      s.we  = ($urandom_range(0, 2) == 0);
      s.wa  = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : wa_tab[$urandom_range(0, 8)];
      s.ra  = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : wa_tab[$urandom_range(0, 8)];
      s.d   = (s.wa == 5'd9 || s.wa == 5'd11) ? 32'($urandom_range(0, 24)) : $urandom;
      if (s.wa == 5'd9 && $urandom_range(0, 7) == 0) s.d = 32'hffff_fffe;
      s.irq = 6'($urandom);
      s.et  = et_tab[$urandom_range(0, 13)];
      s.pc  = $urandom;
      s.ds  = 1'($urandom);
      s.ba  = $urandom;
      // EPC write racing a nested exception is left out of random traffic.
      if (s.we && s.wa == 5'd14 && m_is_exc(s.et) && m_status[1]) s.we = 1'b0;
      drive(s);
    end

    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1);
  end

endmodule

// File: doc/cp0_regfile.md
# cp0_regfile

Coprocessor-0 register file for the MIPS core. It consumes the prioritised `excepttype` word from the exception encoder and commits exception state: EPC, Cause, Status.EXL and BadVAddr. It services `mtc0`/`mfc0` and runs the Count/Compare timer. It sits at the memory/writeback boundary, next to the exception encoder. Its Status and Cause outputs feed back into that encoder.

## Interface
- No parameters. PRId is the constant 32'h0000_4220. Config is the constant 32'h0000_8000.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset; one clock, sampled on the rising edge of `clk`.
- `we_i` in 1: mtc0 write enable.
- `waddr_i` in 5: mtc0 register number.
- `raddr_i` in 5: mfc0 register number.
- `data_i` in 32: mtc0 data.
- `int_i` in 6: hardware interrupt lines 5..0, level-sensitive.
- `excepttype_i` in 32: exception code from the encoder. 0 = none.
- `current_inst_addr_i` in 32: PC of the excepting instruction.
- `is_in_delayslot_i` in 1: the excepting instruction is in a delay slot.
- `bad_addr_i` in 32: faulting address for ADEL/ADES.
- `data_o` out 32: mfc0 read data.
- `status_o` out 32, `cause_o` out 32, `epc_o` out 32, `badvaddr_o` out 32, `count_o` out 32, `compare_o` out 32: register contents.
- `timer_int_o` out 1: Count/Compare match interrupt.

## Operation
- **Register numbers:** BadVAddr 8, Count 9, Compare 11, Status 12, Cause 13, EPC 14, PRId 15, Config 16.
- **Reads:** `data_o` is combinational from the current register values. There is no write bypass. Unmapped numbers read 0.
- **Write masks (mtc0):**
  - Status: only bits [15:8], [1] and [0] are written. Bit 22 (BEV) is fixed at 1. All other bits read 0.
  - Cause: only bits [9:8] (software IP) are written.
  - EPC, Count and Compare: all 32 bits are written.
  - BadVAddr, PRId and Config: writes are ignored.
- **Cause IP sampling:** every cycle, Cause[15:10] <= {int_i[5] | timer_int_o, int_i[4:0]}.
- **Exception commit** applies when `excepttype_i` is one of 01, 04, 05, 08, 09, 0a or 0c:
  - If Status.EXL = 0: EPC <= `current_inst_addr_i` - 4 when `is_in_delayslot_i` is set, otherwise `current_inst_addr_i`; Cause[31] (BD) <= `is_in_delayslot_i`.
  - If Status.EXL = 1: EPC and BD are unchanged.
  - In both cases: Status.EXL <= 1.
  - Cause[6:2] <= code. Code 01 maps to ExcCode 00; every other code maps to itself.
  - Codes 04 and 05 also load BadVAddr <= `bad_addr_i`.
- **ERET** (`excepttype_i` = 0x0e): Status.EXL <= 0. Nothing else changes.
- **Other values:** any other non-zero `excepttype_i` is ignored.
- **Simultaneous mtc0 and exception/ERET in one cycle:**
  - The exception/ERET update wins on the fields it writes: EPC, BD, ExcCode, EXL, BadVAddr.
  - The mtc0 still applies to its remaining masked bits.
- **Timer:**
  - A 1-bit tick toggles every cycle. Count increments when tick = 1, i.e. every second cycle, wrapping 0xFFFF_FFFF -> 0.
  - `timer_int_o` is set the cycle after Count == Compare while Compare != 0.
  - It is held until an mtc0 to Compare, which clears it.
  - An mtc0 to Count overrides that cycle's increment.

## Timing
- Every state update is registered on the rising edge of `clk`, with one cycle of latency from the inputs. A register written in cycle N is visible on `data_o` and the register outputs in cycle N+1.
- **Reset values:**
  - Status = 32'h0040_0000.
  - Cause, EPC, BadVAddr, Count, Compare = 0.
  - tick = 0, `timer_int_o` = 0.
- **Reset mid-operation:** `rst` overrides every write, exception and timer event in that cycle.
- Exceptions presented on consecutive cycles are each committed. The second one sees EXL = 1, so EPC is preserved.

## Structure
- **Shared package `cp0_defs`:**
  - Register-number constants (`CP0_REG_BADVADDR` … `CP0_REG_CONFIG`).
  - Exception codes (`EXC_INT`=01, `EXC_ADEL`=04, `EXC_ADES`=05, `EXC_SYS`=08, `EXC_BP`=09, `EXC_RI`=0a, `EXC_OV`=0c, `EXC_ERET`=0e).
  - Status and Cause write masks.
  - The PRId and Config constants.
  - This package is shared with the exception encoder.
- **Sub-module `cp0_timer`:** Count, Compare, tick and `timer_int_o`, with its own write ports.

## Test plan
- **Reset:** assert `rst` for one cycle -> Status = 0040_0000, all other outputs 0, `data_o` reading PRId = 0000_4220.
- **Syscall:** `excepttype_i`=08, PC=BFC0_0100, not in delay slot -> EPC = BFC0_0100, Cause[6:2] = 08, BD = 0, Status.EXL = 1. Then `excepttype_i`=0e -> EXL = 0.
- **Delay-slot ADEL:** `excepttype_i`=04, PC=8000_0010, delay slot = 1, bad address 8000_0003 -> EPC = 8000_000C, BD = 1, BadVAddr = 8000_0003. A second exception (0c) next cycle -> EPC unchanged, ExcCode = 0c.
- **mtc0 masking:** write Status = FFFF_FFFF -> Status reads 0040_FF03. Write Cause = FFFF_FFFF -> only [9:8] set.
- **Timer:** write Compare = 5 and Count = 0 -> Count reaches 5 after 10 cycles, `timer_int_o` = 1 and Cause[15] = 1 the next cycle. An mtc0 to Compare clears `timer_int_o`.
- **Collision:** mtc0 EPC = 1234_5678 in the same cycle as `excepttype_i`=0c, PC=8000_0040 -> EPC = 8000_0040.
